// File: rtl/piso_sched_pkg.sv
// ----------------------------------------------------------------------------
// piso_sched_pkg
// Shared types and helpers for the PISO round-robin scheduler.
//   state_t    : scheduler FSM states
//   cnt_width  : width of a down-counter that must hold values 0..value-1,
//                never less than one bit so zero-range counters stay legal
// ----------------------------------------------------------------------------
package piso_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int STATS_CNT_WIDTH = 16;

    function automatic int cnt_width(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/piso_sched_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search starts one past the last
// winner and wraps, so the most recently served requester has lowest
// priority.
// Ports:
//   req    in  NUM_REQ          request vector
//   ptr    in  $clog2(NUM_REQ)  index of the last winner
//   grant  out NUM_REQ          one-hot winner (all zero if no request)
//   idx    out $clog2(NUM_REQ)  index of the winner
//   any    out 1                at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin
        int cand;
        cand  = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(ptr) + off) % NUM_REQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/piso_sched.sv
// ----------------------------------------------------------------------------
// piso_sched
// Round-robin scheduler sharing one PISO serializer between NUM_REQ
// parallel-word requesters. One word is accepted per valid/ready handshake,
// loaded into the PISO, framed for DATA_WIDTH bit-times and followed by
// GAP_CYCLES idle bit-times before the next grant.
//
// Ports:
//   i_clk         in   1                   clock, posedge
//   i_s_rst       in   1                   synchronous reset, active-high
//   i_en          in   1                   allow new grants
//   i_req_valid   in   NUM_REQ             per-requester valid
//   i_req_data    in   NUM_REQ*DATA_WIDTH  packed words, k at [k*DW +: DW]
//   o_req_ready   out  NUM_REQ             one-hot accept, combinational
//   o_piso_wr_en  out  1                   PISO load strobe, registered
//   o_piso_data   out  DATA_WIDTH          PISO word, held until next load
//   o_frame       out  1                   serial bits valid
//   o_owner       out  $clog2(NUM_REQ)     requester of the word in flight
//   o_busy        out  1                   FSM not idle
//   o_word_cnt    out  NUM_REQ*16          per-requester accepted words
//                                          (only with PISO_SCHED_STATS_EN)
//
// Build option: define PISO_SCHED_STATS_EN to add o_word_cnt.
//
// state | meaning
// IDLE  | waiting; offers the round-robin winner while enabled
// LOAD  | PISO load strobe, first serial bit-time
// SHIFT | remaining DATA_WIDTH-1 serial bit-times
// GAP   | GAP_CYCLES idle bit-times before the next grant
// ----------------------------------------------------------------------------
module piso_sched
    import piso_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic                            i_clk,
    input  logic                            i_s_rst,
    input  logic                            i_en,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]              o_req_ready,
    output logic                            o_piso_wr_en,
    output logic [DATA_WIDTH-1:0]           o_piso_data,
    output logic                            o_frame,
    output logic [$clog2(NUM_REQ)-1:0]      o_owner,
    output logic                            o_busy
`ifdef PISO_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*STATS_CNT_WIDTH-1:0] o_word_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BIT_W = cnt_width(DATA_WIDTH);
    localparam int GAP_W = cnt_width(GAP_CYCLES + 1);

    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_REQ - 1);
    localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(DATA_WIDTH - 2);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        ptr;
    logic [BIT_W-1:0]        bit_cnt;
    logic [GAP_W-1:0]        gap_cnt;
    logic                    hs;

    logic [NUM_REQ-1:0]      grant;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_any;
    logic [DATA_WIDTH-1:0]   sel_word;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (i_req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign sel_word = i_req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];

    // Ready is also masked by reset so every output reads 0 while reset is held.
    always_comb begin
        state_nxt   = state;
        o_req_ready = '0;
        hs          = 1'b0;
        unique case (state)
            IDLE: begin
                if (!i_s_rst && i_en && grant_any) begin
                    o_req_ready = grant;
                    hs          = 1'b1;
                    state_nxt   = LOAD;
                end
            end
            LOAD: begin
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (bit_cnt == '0) begin
                    state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Both counters are preset on the handshake; each only runs in its own state.
    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            state        <= IDLE;
            ptr          <= PTR_RST;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            o_piso_wr_en <= 1'b0;
            o_piso_data  <= '0;
            o_owner      <= '0;
        end else begin
            state        <= state_nxt;
            o_piso_wr_en <= hs;
            if (hs) begin
                o_piso_data <= sel_word;
                o_owner     <= grant_idx;
                ptr         <= grant_idx;
                bit_cnt     <= BIT_LOAD;
                gap_cnt     <= GAP_LOAD;
            end else begin
                if (state == SHIFT && bit_cnt != '0) begin
                    bit_cnt <= bit_cnt - 1'b1;
                end
                if (state == GAP && gap_cnt != '0) begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
            end
        end
    end

    assign o_frame = (state == LOAD) || (state == SHIFT);
    assign o_busy  = (state != IDLE);

`ifdef PISO_SCHED_STATS_EN
    logic [STATS_CNT_WIDTH-1:0] word_cnt [NUM_REQ];

    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                word_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (hs && grant_idx == IDX_W'(k)) begin
                    word_cnt[k] <= word_cnt[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_word_cnt = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            o_word_cnt[k*STATS_CNT_WIDTH +: STATS_CNT_WIDTH] = word_cnt[k];
        end
    end
`endif

endmodule
